chip8_keypad: RTL and testbench

CHIP8_KEYPAD -- requirements
Module: chip8_keypad

---
 rtl/chip8_keypad_pkg.sv | 17 +
 rtl/chip8_keypad_if.sv | 17 +
 rtl/chip8_keypad_sync2.sv | 17 +
 rtl/chip8_keypad.sv | 62 ++++++
 tb/tb_chip8_keypad.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/chip8_keypad_pkg.sv
// chip8_keypad_pkg: shared CHIP-8 keypad constants (matrix-to-key map, "no key" code) and a lowest-key helper
package chip8_keypad_pkg;
    localparam logic [4:0] NO_KEY = 5'd16;
    // Indexed by matrix position {row, col}; value is the CHIP-8 key printed on that button.
    localparam logic [3:0] KEY_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hC,
        4'h4, 4'h5, 4'h6, 4'hD,
        4'h7, 4'h8, 4'h9, 4'hE,
        4'hA, 4'h0, 4'hB, 4'hF
    };
    function automatic logic [4:0] lowest_key(input logic [15:0] keys);
        logic [4:0] k;
        k = NO_KEY;
        for (int i = 15; i >= 0; i--) if (keys[i]) k = 5'(i);
        return k;
    endfunction
endpackage

// File: rtl/chip8_keypad_if.sv
// chip8_keypad_if: keypad bus -- row_n/col_n to the matrix, input_keys/newest_key_down/clear_newest_key_down to the core
// master: the keypad block (drives rows and key state); slave: matrix + core side
interface chip8_keypad_if;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] input_keys;
    logic [4:0]  newest_key_down;
    logic        clear_newest_key_down;
    modport master (
        output row_n, input_keys, newest_key_down,
        input  col_n, clear_newest_key_down
    );
    modport slave (
        input  row_n, input_keys, newest_key_down,
        output col_n, clear_newest_key_down
    );
endinterface

// File: rtl/chip8_keypad_sync2.sv
// sync2: two-flop synchronizer, WIDTH bits, reset to INIT
// ports: clk, rst (sync, active-high), d (async in), q (synchronized out)
module sync2 #(
    parameter int WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;
    always_ff @(posedge clk) begin
        if (rst) {q, meta} <= {INIT, INIT};
        else {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/chip8_keypad.sv
// chip8_keypad: 4x4 matrix scanner with frame debounce, producing CHIP-8 key state and the newest pressed key
// ports: clk, rst (sync, active-high), bus (master modport: row_n, col_n, input_keys, newest_key_down, clear_newest_key_down)
module chip8_keypad
    import chip8_keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst,
    chip8_keypad_if.master bus
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    logic [3:0]    col_s;
    logic [DW-1:0] div;
    logic [1:0]    row;
    logic [15:0]   frame, prev_frame, frame_nxt, new_press;
    logic [SW-1:0] stable;
    logic          frame_done, clr_prev, sample, load;
    sync2 #(.WIDTH(4), .INIT(4'hF)) u_sync (.clk(clk), .rst(rst), .d(bus.col_n), .q(col_s));
    assign sample    = div == DW'(SCAN_DIV - 1);
    assign bus.row_n = ~(4'b0001 << row);
    // Each row overwrites its own four bits, so the frame never needs an explicit clear.
    always_comb begin
        frame_nxt = frame;
        for (int c = 0; c < 4; c++) frame_nxt[KEY_MAP[{row, 2'(c)}]] = ~col_s[c];
    end
    // Loading happens the cycle after the frame that made the count reach its target.
    assign load      = frame_done && stable == SW'(DEBOUNCE_SCANS);
    assign new_press = prev_frame & ~bus.input_keys;
    always_ff @(posedge clk) begin
        if (rst) begin
            div                 <= '0;
            row                 <= '0;
            frame               <= '0;
            prev_frame          <= '0;
            stable              <= '0;
            frame_done          <= 1'b0;
            clr_prev            <= 1'b0;
            bus.input_keys      <= '0;
            bus.newest_key_down <= NO_KEY;
        end else begin
            div        <= sample ? '0 : div + 1'b1;
            clr_prev   <= bus.clear_newest_key_down;
            frame_done <= sample && row == 2'd3;
            if (sample) begin
                frame <= frame_nxt;
                row   <= row + 2'd1;
                if (row == 2'd3) begin
                    prev_frame <= frame_nxt;
                    stable     <= (frame_nxt != prev_frame) ? SW'(1) :
                                  (stable == SW'(DEBOUNCE_SCANS)) ? stable : stable + 1'b1;
                end
            end
            if (load) bus.input_keys <= prev_frame;
            // A fresh press outranks a clear arriving in the same cycle.
            if (load && |new_press) bus.newest_key_down <= lowest_key(new_press);
            else if (bus.clear_newest_key_down && !clr_prev) bus.newest_key_down <= NO_KEY;
        end
    end
endmodule

// File: tb/tb_chip8_keypad.sv
// tb_chip8_keypad: directed bench for chip8_keypad with SCAN_DIV=4, DEBOUNCE_SCANS=2 (16-cycle frames)
module tb_chip8_keypad;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pos = '0;
    logic [3:0]  cn;
    int          checks = 0;
    int          fails = 0;

    chip8_keypad_if bus();

    chip8_keypad #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Matrix model: a pressed button at (r,c) pulls column c low while row r is driven.
    always_comb begin
        cn = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pos[r*4+c] && !bus.row_n[r]) cn[c] = 1'b0;
    end
    assign bus.col_n = cn;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench #1 after the last reset edge; the next posedge is the first scan cycle.
    task automatic do_reset;
        rst = 1'b1;
        pos = '0;
        bus.clear_newest_key_down = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] exp_rows [5];
        exp_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        do_reset;
        checks++; if (bus.row_n !== 4'b1110) begin fails++; $display("FAIL reset_row_n got %b want 1110", bus.row_n); end
        checks++; if (bus.input_keys !== 16'h0000) begin fails++; $display("FAIL reset_input_keys got %h want 0000", bus.input_keys); end
        checks++; if (bus.newest_key_down !== 5'd16) begin fails++; $display("FAIL reset_newest got %0d want 16", bus.newest_key_down); end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick(4);
            checks++; if (bus.row_n !== exp_rows[i]) begin fails++; $display("FAIL row_step_%0d got %b want %b", i, bus.row_n, exp_rows[i]); end
        end
        tick(20);
        checks++; if (bus.input_keys !== 16'h0000) begin fails++; $display("FAIL idle_input_keys got %h want 0000", bus.input_keys); end
        checks++; if (bus.newest_key_down !== 5'd16) begin fails++; $display("FAIL idle_newest got %0d want 16", bus.newest_key_down); end
    endtask

    task automatic test_single_press;
        do_reset;
        pos[6] = 1'b1;
        tick(32);
        checks++; if (bus.input_keys !== 16'h0000) begin fails++; $display("FAIL single_early got %h want 0000", bus.input_keys); end
        tick(1);
        checks++; if (bus.input_keys !== 16'h0040) begin fails++; $display("FAIL single_keys got %h want 0040", bus.input_keys); end
        checks++; if (bus.newest_key_down !== 5'd6) begin fails++; $display("FAIL single_newest got %0d want 6", bus.newest_key_down); end
    endtask

    task automatic test_bounce;
        do_reset;
        for (int f = 0; f < 4; f++) begin
            pos[6] = (f % 2 == 0);
            tick(16);
            checks++; if (bus.input_keys !== 16'h0000) begin fails++; $display("FAIL bounce_frame_%0d got %h want 0000", f, bus.input_keys); end
        end
        pos[6] = 1'b1;
        tick(32);
        checks++; if (bus.input_keys !== 16'h0000) begin fails++; $display("FAIL bounce_settle_early got %h want 0000", bus.input_keys); end
        tick(1);
        checks++; if (bus.input_keys !== 16'h0040) begin fails++; $display("FAIL bounce_keys got %h want 0040", bus.input_keys); end
        checks++; if (bus.newest_key_down !== 5'd6) begin fails++; $display("FAIL bounce_newest got %0d want 6", bus.newest_key_down); end
    endtask

    task automatic test_clear;
        do_reset;
        pos[6] = 1'b1;
        tick(33);
        checks++; if (bus.newest_key_down !== 5'd6) begin fails++; $display("FAIL clear_pre got %0d want 6", bus.newest_key_down); end
        bus.clear_newest_key_down = 1'b1;
        tick(1);
        checks++; if (bus.newest_key_down !== 5'd16) begin fails++; $display("FAIL clear_rise got %0d want 16", bus.newest_key_down); end
        pos[13] = 1'b1;
        tick(30);
        checks++; if (bus.input_keys !== 16'h0040) begin fails++; $display("FAIL clear_second_early got %h want 0040", bus.input_keys); end
        checks++; if (bus.newest_key_down !== 5'd16) begin fails++; $display("FAIL clear_held got %0d want 16", bus.newest_key_down); end
        tick(1);
        checks++; if (bus.input_keys !== 16'h0041) begin fails++; $display("FAIL clear_second_keys got %h want 0041", bus.input_keys); end
        checks++; if (bus.newest_key_down !== 5'd0) begin fails++; $display("FAIL clear_second_newest got %0d want 0", bus.newest_key_down); end
        bus.clear_newest_key_down = 1'b0;
        pos[13] = 1'b0;
        tick(32);
        checks++; if (bus.input_keys !== 16'h0040) begin fails++; $display("FAIL release_keys got %h want 0040", bus.input_keys); end
        checks++; if (bus.newest_key_down !== 5'd0) begin fails++; $display("FAIL release_newest got %0d want 0", bus.newest_key_down); end
    endtask

    task automatic test_multi;
        do_reset;
        pos[0]  = 1'b1;
        pos[15] = 1'b1;
        tick(32);
        bus.clear_newest_key_down = 1'b1;
        tick(1);
        checks++; if (bus.input_keys !== 16'h8002) begin fails++; $display("FAIL multi_keys got %h want 8002", bus.input_keys); end
        checks++; if (bus.newest_key_down !== 5'd1) begin fails++; $display("FAIL multi_newest got %0d want 1", bus.newest_key_down); end
    endtask

    task automatic test_reset_mid;
        do_reset;
        pos[8] = 1'b1;
        tick(33);
        checks++; if (bus.input_keys !== 16'h0080) begin fails++; $display("FAIL mid_pre_keys got %h want 0080", bus.input_keys); end
        checks++; if (bus.newest_key_down !== 5'd7) begin fails++; $display("FAIL mid_pre_newest got %0d want 7", bus.newest_key_down); end
        tick(8);
        checks++; if (bus.row_n !== 4'b1011) begin fails++; $display("FAIL mid_row2 got %b want 1011", bus.row_n); end
        rst = 1'b1;
        tick(1);
        checks++; if (bus.row_n !== 4'b1110) begin fails++; $display("FAIL mid_rst_row_n got %b want 1110", bus.row_n); end
        checks++; if (bus.input_keys !== 16'h0000) begin fails++; $display("FAIL mid_rst_keys got %h want 0000", bus.input_keys); end
        checks++; if (bus.newest_key_down !== 5'd16) begin fails++; $display("FAIL mid_rst_newest got %0d want 16", bus.newest_key_down); end
        tick(1);
        rst = 1'b0;
        tick(32);
        checks++; if (bus.input_keys !== 16'h0000) begin fails++; $display("FAIL mid_after_early got %h want 0000", bus.input_keys); end
        tick(1);
        checks++; if (bus.input_keys !== 16'h0080) begin fails++; $display("FAIL mid_after_keys got %h want 0080", bus.input_keys); end
        checks++; if (bus.newest_key_down !== 5'd7) begin fails++; $display("FAIL mid_after_newest got %0d want 7", bus.newest_key_down); end
    endtask

    initial begin
        bus.clear_newest_key_down = 1'b0;
        test_reset;
        test_single_press;
        test_bounce;
        test_clear;
        test_multi;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
